// File: rtl/im_load_ctrl.sv
// Instruction-memory port owner: muxes CPU fetch against a UART bootloader that
// streams a word-count header and 17-bit words (3 bytes each) into the memory.
`timescale 1ns/1ps
module im_load_ctrl #(
   parameter int unsigned IM_DEPTH     = 2048,
   parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
   parameter logic [31:0] BOOT_TIMEOUT = 32'd100000,
   parameter logic [31:0] BYTE_TIMEOUT = 32'd50000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_rdy,
   input  logic [7:0]  rx_data,
   output logic        clr_rx_rdy,
   input  logic [15:0] cpu_addr,
   input  logic        cpu_rd_en,
   output logic [15:0] im_addr,
   output logic        im_rd_en,
   output logic        im_we,
   output logic [16:0] im_wdata,
   output logic        cpu_hold,
   output logic        load_done,
   output logic        load_err
);

   localparam int unsigned AW  = $clog2(IM_DEPTH);
   localparam int unsigned WLW = AW + 1;

   typedef enum logic [3:0] {
      WAIT_SYNC, CNT_H, CNT_L, B2, B1, B0, WRITE, DONE, RUN, ERR
   } state_t;

   state_t           state_q, state_d;
   logic [31:0]      cnt_q, cnt_d;
   logic [7:0]       hi_q, hi_d;
   logic [16:0]      word_q, word_d;
   logic [AW-1:0]    wr_addr_q, wr_addr_d;
   logic [WLW-1:0]   left_q, left_d;
   logic             clr_q;
   logic             done_q, done_d;
   logic             err_q, err_d;

   logic             accept;
   logic             is_sync;
   logic             in_load;
   logic [15:0]      n_word;

   // Bytes are held off in WRITE/DONE so a SYNC arriving right behind the last
   // data byte waits for RUN instead of being swallowed.
   assign accept  = rx_rdy && !clr_q && (state_q != WRITE) && (state_q != DONE);
   assign is_sync = accept && (rx_data == SYNC_BYTE);
   assign in_load = state_q inside {CNT_H, CNT_L, B2, B1, B0};
   assign n_word  = {hi_q, rx_data};

   always_comb begin
      state_d   = state_q;
      cnt_d     = '0;
      hi_d      = hi_q;
      word_d    = word_q;
      wr_addr_d = wr_addr_q;
      left_d    = left_q;
      done_d    = done_q;
      err_d     = err_q;

      case (state_q)
         WAIT_SYNC: begin
            if (is_sync) begin
               state_d = CNT_H;
               done_d  = 1'b0;
               err_d   = 1'b0;
            end else if (cnt_q == BOOT_TIMEOUT) begin
               state_d = RUN;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         CNT_H: if (accept) begin
            hi_d    = rx_data;
            state_d = CNT_L;
         end
         CNT_L: if (accept) begin
            if (n_word == 16'd0) begin
               state_d = DONE;
            end else if ({16'd0, n_word} > IM_DEPTH) begin
               state_d = ERR;
               err_d   = 1'b1;
            end else begin
               wr_addr_d = '0;
               left_d    = n_word[WLW-1:0];
               state_d   = B2;
            end
         end
         B2: if (accept) begin
            word_d[16] = rx_data[0];
            state_d    = B1;
         end
         B1: if (accept) begin
            word_d[15:8] = rx_data;
            state_d      = B0;
         end
         B0: if (accept) begin
            word_d[7:0] = rx_data;
            state_d     = WRITE;
         end
         WRITE: begin
            wr_addr_d = wr_addr_q + AW'(1);
            left_d    = left_q - WLW'(1);
            state_d   = (left_q == WLW'(1)) ? DONE : B2;
         end
         DONE: begin
            done_d  = 1'b1;
            err_d   = 1'b0;
            state_d = RUN;
         end
         RUN, ERR: begin
            if (is_sync) begin
               state_d = CNT_H;
               done_d  = 1'b0;
               err_d   = 1'b0;
            end
         end
         default: state_d = WAIT_SYNC;
      endcase

      // Inter-byte idle timer shared by every header/data byte state.
      if (in_load) begin
         if (accept) begin
            cnt_d = '0;
         end else if (cnt_q == BYTE_TIMEOUT - 32'd1) begin
            state_d = ERR;
            err_d   = 1'b1;
         end else begin
            cnt_d = cnt_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= WAIT_SYNC;
         cnt_q     <= '0;
         hi_q      <= '0;
         word_q    <= '0;
         wr_addr_q <= '0;
         left_q    <= '0;
         clr_q     <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         word_q    <= word_d;
         wr_addr_q <= wr_addr_d;
         left_q    <= left_d;
         clr_q     <= accept;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign cpu_hold   = (state_q != RUN);
   assign im_we      = (state_q == WRITE);
   assign im_wdata   = word_q;
   assign clr_rx_rdy = clr_q;
   assign load_done  = done_q;
   assign load_err   = err_q;
   assign im_addr    = cpu_hold ? {{(16-AW){1'b0}}, wr_addr_q} : cpu_addr;
   assign im_rd_en   = cpu_hold ? 1'b0 : cpu_rd_en;

endmodule

// File: tb/tb_im_load_ctrl.sv
// Scoreboarded bench for im_load_ctrl: a UART driver issues byte streams and
// pushes the writes they should cause; a negedge monitor checks each write.
`timescale 1ns/1ps
module tb_im_load_ctrl;

   localparam int unsigned DEPTH   = 2048;
   localparam logic [31:0] BOOT_TO = 32'd200;
   localparam logic [31:0] BYTE_TO = 32'd100;

   logic        clk, rst;
   logic        rx_rdy;
   logic [7:0]  rx_data;
   logic        clr_rx_rdy;
   logic [15:0] cpu_addr;
   logic        cpu_rd_en;
   logic [15:0] im_addr;
   logic        im_rd_en, im_we;
   logic [16:0] im_wdata;
   logic        cpu_hold, load_done, load_err;

   im_load_ctrl #(
      .IM_DEPTH     (DEPTH),
      .SYNC_BYTE    (8'hA5),
      .BOOT_TIMEOUT (BOOT_TO),
      .BYTE_TIMEOUT (BYTE_TO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_rdy     (rx_rdy),
      .rx_data    (rx_data),
      .clr_rx_rdy (clr_rx_rdy),
      .cpu_addr   (cpu_addr),
      .cpu_rd_en  (cpu_rd_en),
      .im_addr    (im_addr),
      .im_rd_en   (im_rd_en),
      .im_we      (im_we),
      .im_wdata   (im_wdata),
      .cpu_hold   (cpu_hold),
      .load_done  (load_done),
      .load_err   (load_err)
   );

   typedef struct {
      logic [15:0] addr;
      logic [16:0] data;
   } wr_t;

   wr_t         exp_q[$];
   logic [16:0] mem [0:DEPTH-1];
   logic [16:0] img [0:DEPTH-1];
   int total = 0, bad = 0;
   int cyc = 0, clr_cnt = 0, last_clr_cyc = 0, last_we_cyc = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: models the memory and scores every write against the queue.
   always @(negedge clk) begin
      if (!rst) begin
         if (clr_rx_rdy) begin
            clr_cnt++;
            last_clr_cyc = cyc;
         end
         if (im_we) begin
            wr_t e;
            mem[im_addr[10:0]] = im_wdata;
            last_we_cyc = cyc;
            chk("we_hold", cpu_hold, 1);
            chk("we_rd_en", im_rd_en, 0);
            chk("write_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("wr_addr", im_addr, e.addr);
               chk("wr_data", im_wdata, e.data);
            end
         end
      end
   end

   task automatic present(input logic [7:0] b);
      @(negedge clk);
      rx_data = b;
      rx_rdy  = 1'b1;
   endtask

   // UART keeps rx_rdy high until it sees the consume pulse.
   task automatic wait_ack();
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (clr_rx_rdy) break;
      end
      chk("byte_ack", clr_rx_rdy, 1);
      rx_rdy = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      repeat (gap) @(negedge clk);
      present(b);
      wait_ack();
   endtask

   task automatic send_word(input logic [16:0] w, input int gapmax);
      send_byte({7'($urandom), w[16]}, $urandom_range(0, gapmax));
      send_byte(w[15:8], $urandom_range(0, gapmax));
      send_byte(w[7:0], $urandom_range(0, gapmax));
   endtask

   task automatic push_exp(input int n);
      for (int i = 0; i < n; i++) exp_q.push_back('{addr: 16'(i), data: img[i]});
   endtask

   task automatic send_body(input int n, input int gapmax);
      logic [15:0] nn;
      nn = 16'(n);
      send_byte(nn[15:8], $urandom_range(0, gapmax));
      send_byte(nn[7:0], $urandom_range(0, gapmax));
      for (int i = 0; i < n; i++) send_word(img[i], gapmax);
   endtask

   task automatic load_img(input int n, input int gapmax);
      for (int i = 0; i < n; i++) img[i] = 17'($urandom);
      push_exp(n);
      send_byte(8'hA5, $urandom_range(0, gapmax));
      send_body(n, gapmax);
   endtask

   task automatic wait_done(input bit lat);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!cpu_hold) break;
      end
      chk("hold_release", cpu_hold, 0);
      chk("load_done", load_done, 1);
      chk("load_err_clear", load_err, 0);
      chk("sb_drained", exp_q.size(), 0);
      if (lat) begin
         chk("we_to_run_lat", cyc - last_we_cyc, 2);
         chk("ack_to_we_lat", last_clr_cyc - last_we_cyc, 0);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_cpu_hold"}, cpu_hold, 1);
      chk({tag, "_clr"}, clr_rx_rdy, 0);
      chk({tag, "_we"}, im_we, 0);
      chk({tag, "_wdata"}, im_wdata, 0);
      chk({tag, "_done"}, load_done, 0);
      chk({tag, "_err"}, load_err, 0);
      chk({tag, "_rd_en"}, im_rd_en, 0);
   endtask

   initial begin
      #(10 * 90000);
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin
      int c0;
      logic [7:0] junk;
      int n;
      rst = 1'b1; rx_rdy = 1'b0; rx_data = '0; cpu_addr = 16'h1234; cpu_rd_en = 1'b1;
      repeat (3) @(posedge clk);
      #1 chk_reset_vals("rst");

      // Boot timeout: hold drops on the (BOOT_TO+1)-th edge after release.
      @(negedge clk) rst = 1'b0;
      for (int k = 1; k <= int'(BOOT_TO) + 1; k++) begin
         @(posedge clk);
         #1;
         if (k == int'(BOOT_TO)) chk("boot_hold_before", cpu_hold, 1);
      end
      chk("boot_release", cpu_hold, 0);
      for (int i = 0; i < 4; i++) begin
         cpu_addr  = 16'($urandom);
         cpu_rd_en = 1'($urandom);
         #2;
         chk("mux_addr", im_addr, cpu_addr);
         chk("mux_rd_en", im_rd_en, cpu_rd_en);
      end

      // Directed two-word load.
      img[0] = 17'h12345;
      img[1] = 17'h00007;
      push_exp(2);
      send_byte(8'hA5, 0); send_byte(8'h00, 1); send_byte(8'h02, 0);
      send_byte(8'h01, 0); send_byte(8'h23, 2); send_byte(8'h45, 0);
      send_byte(8'h00, 0); send_byte(8'h00, 1); send_byte(8'h07, 0);
      wait_done(1);
      chk("mem0", mem[0], 17'h12345);
      chk("mem1", mem[1], 17'h00007);

      // Oversized count, then an empty load recovers.
      send_byte(8'hA5, 0); send_byte(8'h08, 0); send_byte(8'h01, 0);
      repeat (3) @(negedge clk);
      chk("oversize_err", load_err, 1);
      chk("oversize_hold", cpu_hold, 1);
      chk("oversize_done", load_done, 0);
      send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
      wait_done(0);

      // SYNC while the CPU is fetching.
      cpu_rd_en = 1'b1;
      cpu_addr  = 16'($urandom);
      for (int i = 0; i < 3; i++) img[i] = 17'($urandom);
      push_exp(3);
      present(8'hA5);
      @(posedge clk);
      #1;
      chk("sync_hold", cpu_hold, 1);
      chk("sync_rd_en", im_rd_en, 0);
      chk("sync_done_clr", load_done, 0);
      chk("byte_ack", clr_rx_rdy, 1);
      rx_rdy = 1'b0;
      send_body(3, 2);
      wait_done(1);

      // Inter-byte timeout after the first data byte.
      c0 = clr_cnt;
      send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h01, 0); send_byte(8'h01, 0);
      for (int i = 0; i < int'(BYTE_TO) + 20; i++) begin
         @(negedge clk);
         if (load_err) break;
      end
      chk("timeout_err", load_err, 1);
      chk("timeout_cycles", cyc - last_clr_cyc, BYTE_TO);
      chk("timeout_hold", cpu_hold, 1);
      chk("one_ack_per_byte", clr_cnt - c0, 4);
      chk("timeout_no_write", exp_q.size(), 0);

      // Randomized loads, some preceded by a discarded non-SYNC byte.
      for (int it = 0; it < 6; it++) begin
         if ($urandom_range(0, 1) == 1) begin
            junk = 8'($urandom_range(0, 255));
            if (junk == 8'hA5) junk = 8'h5A;
            send_byte(junk, 1);
         end
         n = $urandom_range(0, 4);
         load_img(n, 3);
         wait_done(n != 0);
         for (int i = 0; i < n; i++) chk("rand_mem", mem[i], img[i]);
      end

      // Full-depth load: the largest legal count.
      load_img(DEPTH, 0);
      wait_done(1);
      chk("full_mem_first", mem[0], img[0]);
      chk("full_mem_last", mem[DEPTH-1], img[DEPTH-1]);

      // Reset during B1 of word 3 keeps words 0-2.
      for (int i = 0; i < 5; i++) img[i] = 17'($urandom) | 17'h1;
      push_exp(3);
      send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h05, 0);
      for (int i = 0; i < 3; i++) send_word(img[i], 1);
      send_byte({7'($urandom), img[3][16]}, 0);
      #2 rst = 1'b1;
      #1 chk_reset_vals("midload");
      for (int i = 0; i < 3; i++) chk("partial_mem", mem[i], img[i]);
      chk("partial_sb", exp_q.size(), 0);
      @(negedge clk) rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("post_rst_hold", cpu_hold, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
